// File: rtl/fp_pkg.sv
// Shared binary32 definitions used by the FP add/sub responder and its peers.
package fp_pkg;
    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADDSUB,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } add_state_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.man == '0);
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter for the 28-bit add/sub sum; all-zero gives 28.
module fp_lzc (
    input  logic [27:0] i_val,
    output logic [4:0]  o_cnt
);
    always_comb begin
        o_cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (i_val[i]) o_cnt = 5'(27 - i);
        end
    end
endmodule

// File: rtl/fp_add_responder.sv
// Multi-cycle binary32 add/subtract responder, one request in flight, fixed latency.
// FP_ADD_SUBNORMAL_EN: when defined, subnormal inputs/outputs are supported; otherwise flush-to-zero.
module fp_add_responder
    import fp_pkg::*;
#(
    parameter int PRECISION = 32,
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Load,
    input  logic                 Op,
    input  logic [PRECISION-1:0] A,
    input  logic [PRECISION-1:0] B,
    output logic [PRECISION-1:0] Result,
    output logic                 Valid
);
    if (PRECISION != FP_W || EXP_W != FP_EXP_W || MAN_W != FP_MAN_W) begin : g_bad_cfg
        $error("fp_add_responder supports binary32 only");
    end

    add_state_t  r_state, w_state_nxt;
    logic        w_accept;

    fp32_t       r_a, r_b;
    logic        r_op;

    logic [26:0] r_sx, r_sy, r_m;
    logic [9:0]  r_ex, r_en;
    logic        r_sgn_x, r_sub, r_zsign, r_zero, r_spec;
    logic [31:0] r_spec_val, r_rnd;
    logic [27:0] r_sum;

    logic [9:0]  w_ea, w_eb, w_ex, w_ey, w_diff;
    logic [23:0] w_sa, w_sb, w_sx, w_sy;
    logic        w_sgn_a, w_sgn_b, w_a_ge;
    logic [26:0] w_y_full, w_y_mask, w_y_al;
    logic        w_spec;
    logic [31:0] w_spec_val;

    logic [4:0]  w_lz, w_want, w_shl;
    logic [9:0]  w_maxsh;
    logic [26:0] w_norm;

    logic        w_inc;
    logic [24:0] w_rnd;
    logic [32:0] w_pack;
    logic [31:0] w_res;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN:  w_state_nxt = ST_ADDSUB;
            ST_ADDSUB: w_state_nxt = ST_NORM;
            ST_NORM:   w_state_nxt = ST_ROUND;
            ST_ROUND:  w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- ALIGN: unpack, swap, shift ----------------
    always_comb begin
        w_ea = {2'b00, r_a.exp};
        w_sa = {1'b1, r_a.man};
        w_eb = {2'b00, r_b.exp};
        w_sb = {1'b1, r_b.man};
`ifdef FP_ADD_SUBNORMAL_EN
        if (r_a.exp == '0) begin w_ea = 10'd1; w_sa = {1'b0, r_a.man}; end
        if (r_b.exp == '0) begin w_eb = 10'd1; w_sb = {1'b0, r_b.man}; end
`else
        if (r_a.exp == '0) begin w_ea = '0; w_sa = '0; end
        if (r_b.exp == '0) begin w_eb = '0; w_sb = '0; end
`endif
        w_sgn_a  = r_a.sign;
        w_sgn_b  = r_b.sign ^ r_op;
        w_a_ge   = {w_ea, w_sa} >= {w_eb, w_sb};
        w_ex     = w_a_ge ? w_ea : w_eb;
        w_ey     = w_a_ge ? w_eb : w_ea;
        w_sx     = w_a_ge ? w_sa : w_sb;
        w_sy     = w_a_ge ? w_sb : w_sa;
        w_diff   = w_ex - w_ey;
        w_y_full = {w_sy, 3'b000};
        w_y_mask = ~(27'h7FF_FFFF << w_diff);
        // Everything shifted past the datapath collapses into the sticky bit.
        if (w_diff >= 10'd27) w_y_al = {26'd0, |w_sy};
        else                  w_y_al = (w_y_full >> w_diff) | {26'd0, |(w_y_full & w_y_mask)};
    end

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = FP_QNAN;
        if (is_nan(r_a) || is_nan(r_b))                       w_spec_val = FP_QNAN;
        else if (is_inf(r_a) && is_inf(r_b) && (w_sgn_a != w_sgn_b)) w_spec_val = FP_QNAN;
        else if (is_inf(r_a))                                 w_spec_val = w_sgn_a ? FP_NEG_INF : FP_POS_INF;
        else if (is_inf(r_b))                                 w_spec_val = w_sgn_b ? FP_NEG_INF : FP_POS_INF;
        else                                                  w_spec     = 1'b0;
    end

    // ---------------- NORM ----------------
    fp_lzc u_lzc (
        .i_val (r_sum),
        .o_cnt (w_lz)
    );

    always_comb begin
        w_want  = w_lz - 5'd1;
        w_maxsh = (r_ex > 10'd1) ? r_ex - 10'd1 : 10'd0;
        w_shl   = ({5'd0, w_want} > w_maxsh) ? w_maxsh[4:0] : w_want;
        // Only used when there is no carry, so bit 27 of the sum is zero.
        w_norm  = r_sum[26:0] << w_shl;
    end

    // ---------------- ROUND ----------------
    always_comb begin
        w_inc  = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        w_rnd  = {1'b0, r_m[26:3]} + {24'd0, w_inc};
        // Hidden bit adds one to the exponent field, so mantissa overflow and
        // subnormal-to-normal promotion fall out of the same addition.
        w_pack = {r_en - 10'd1, 23'd0} + {8'd0, w_rnd};
        if (r_spec)                                   w_res = r_spec_val;
        else if (r_zero)                              w_res = {r_zsign, 31'd0};
`ifndef FP_ADD_SUBNORMAL_EN
        else if (!r_m[26])                            w_res = {r_sgn_x, 31'd0};
`endif
        else if (w_pack[32:23] >= 10'(2*FP_BIAS + 1)) w_res = r_sgn_x ? FP_NEG_INF : FP_POS_INF;
        else                                          w_res = {r_sgn_x, w_pack[30:0]};
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_sx       <= '0;
            r_sy       <= '0;
            r_ex       <= '0;
            r_sgn_x    <= 1'b0;
            r_sub      <= 1'b0;
            r_zsign    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_sum      <= '0;
            r_m        <= '0;
            r_en       <= '0;
            r_zero     <= 1'b0;
            r_rnd      <= '0;
            Result     <= '0;
            Valid      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_op  <= Op;
                Valid <= 1'b0;
            end
            case (r_state)
                ST_ALIGN: begin
                    r_sx       <= {w_sx, 3'b000};
                    r_sy       <= w_y_al;
                    r_ex       <= w_ex;
                    r_sgn_x    <= w_a_ge ? w_sgn_a : w_sgn_b;
                    r_sub      <= w_sgn_a ^ w_sgn_b;
                    r_zsign    <= w_sgn_a & w_sgn_b;
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                end
                ST_ADDSUB: begin
                    r_sum <= r_sub ? ({1'b0, r_sx} - {1'b0, r_sy}) : ({1'b0, r_sx} + {1'b0, r_sy});
                end
                ST_NORM: begin
                    r_zero <= (r_sum == '0);
                    if (r_sum[27]) begin
                        r_m  <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                        r_en <= r_ex + 10'd1;
                    end else begin
                        r_m  <= w_norm;
                        r_en <= r_ex - {5'd0, w_shl};
                    end
                end
                ST_ROUND: r_rnd <= w_res;
                ST_DONE: begin
                    if (!w_accept) begin
                        Result <= r_rnd;
                        Valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_responder.sv
// Self-checking bench: exact-integer reference model of binary32 add/sub plus a cycle-level request model.
module tb_fp_add_responder;
    logic        Clk   = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Load  = 1'b0;
    logic        Op    = 1'b0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic [31:0] Result;
    logic        Valid;

    int checks   = 0;
    int failures = 0;

    fp_add_responder dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Load   (Load),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .Result (Result),
        .Valid  (Valid)
    );

    always #5 Clk = ~Clk;

    // Operand value in units of 2^-149 (the smallest subnormal), exact.
    function automatic logic [319:0] to_units(input logic [31:0] x);
        logic [319:0] v;
        v = '0;
        if (x[30:23] != 8'd0) begin
            v[23:0] = {1'b1, x[22:0]};
            v = v << (x[30:23] - 1);
        end
`ifdef FP_ADD_SUBNORMAL_EN
        else v[22:0] = x[22:0];
`endif
        return v;
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic         sa, sb, sg;
        logic [7:0]   ea, eb;
        logic [319:0] ma, mb, mag, q, rem, half;
        int           p, sh, ex;
        sa = a[31];
        sb = b[31] ^ op;
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0)) return 32'h7FC0_0000;
        if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC0_0000;
        if (ea == 8'hFF) return {sa, 8'hFF, 23'd0};
        if (eb == 8'hFF) return {sb, 8'hFF, 23'd0};
        ma = to_units(a);
        mb = to_units(b);
        if (sa == sb)      begin mag = ma + mb; sg = sa; end
        else if (ma >= mb) begin mag = ma - mb; sg = sa; end
        else               begin mag = mb - ma; sg = sb; end
        if (mag == 0) return {sa & sb, 31'd0};
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        if (p < 23) begin
`ifdef FP_ADD_SUBNORMAL_EN
            return {sg, 8'h00, mag[22:0]};
`else
            return {sg, 31'd0};
`endif
        end
        sh  = p - 23;
        q   = mag >> sh;
        rem = mag - (q << sh);
        if (sh > 0) begin
            half = 320'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q[24]) begin q = q >> 1; sh++; end
        ex = sh + 1;
        if (ex >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, 8'(ex), q[22:0]};
    endfunction

    // Request-level model: accepted when idle or finished; result 5 edges later.
    logic        m_valid = 1'b0, m_pend = 1'b0;
    logic [31:0] m_res = '0, m_exp = '0;
    int          m_edge = 0, m_acc = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_res   = '0;
            m_edge  = 0;
        end else begin
            m_edge++;
            if (Load && (!m_pend || m_edge >= m_acc + 5)) begin
                m_pend  = 1'b1;
                m_acc   = m_edge;
                m_valid = 1'b0;
                m_exp   = ref_add(A, B, Op);
            end else if (m_pend && m_edge == m_acc + 5) begin
                m_valid = 1'b1;
                m_res   = m_exp;
                m_pend  = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        checks++;
        if (Valid !== m_valid) begin
            failures++;
            if (failures < 30) $display("FAIL valid_track t=%0t got=%b exp=%b", $time, Valid, m_valid);
        end else if (m_valid) begin
            checks++;
            if (Result !== m_res) begin
                failures++;
                if (failures < 30) $display("FAIL result_track t=%0t got=%h exp=%h", $time, Result, m_res);
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (Valid !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        if (n >= 20) chk32({nm, "_timeout"}, {31'd0, Valid}, 32'd1);
    endtask

    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic op, input logic [31:0] exp);
        int n;
        @(negedge Clk); Load = 1'b1; A = a; B = b; Op = op;
        @(negedge Clk); Load = 1'b0;
        chk32({nm, "_vfall"}, {31'd0, Valid}, 32'd0);
        wait_valid(nm, n);
        chk32({nm, "_lat"}, n + 1, 32'd6);
        chk32(nm, Result, exp);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0: v[30:0] = '0;
            1: v[30:0] = 31'h7F80_0000;
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: v[30:23] = 8'h00;
            4: v[30:23] = 8'hFE;
            5: v[30:23] = 8'h01;
            default: v[30:23] = 8'(118 + $urandom_range(0, 18));
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rop;
        int          n, low;
        logic        seen;

        repeat (3) @(negedge Clk);
        chk32("reset_valid", {31'd0, Valid}, 32'd0);
        chk32("reset_result", Result, 32'd0);
        #2 Rst_n = 1'b1;

        chk32("model_add15",  ref_add(32'h3FC0_0000, 32'h3FC0_0000, 1'b0), 32'h4040_0000);
        chk32("model_tie",    ref_add(32'h3F80_0000, 32'h3380_0000, 1'b0), 32'h3F80_0000);
        chk32("model_rup",    ref_add(32'h3F80_0000, 32'h3440_0000, 1'b0), 32'h3F80_0002);
        chk32("model_ovf",    ref_add(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0), 32'h7F80_0000);
        chk32("model_negz",   ref_add(32'h8000_0000, 32'h8000_0000, 1'b0), 32'h8000_0000);

        directed("add_1p5",   32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000);
        directed("sub_eq",    32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        directed("tie_even",  32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
        directed("round_up",  32'h3F80_0000, 32'h3440_0000, 1'b0, 32'h3F80_0002);
        directed("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
        directed("neg_zero",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        directed("nan_in",    32'h7FC1_2345, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
`ifdef FP_ADD_SUBNORMAL_EN
        directed("subn",      32'h0080_0000, 32'h0040_0000, 1'b1, 32'h0040_0000);
`else
        directed("subn",      32'h0080_0000, 32'h0040_0000, 1'b1, 32'h0080_0000);
`endif
        directed("max_ovf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);

        // Abort: reset two cycles after Load
        @(negedge Clk); Load = 1'b1; A = 32'h4000_0000; B = 32'h3F80_0000; Op = 1'b0;
        @(negedge Clk); Load = 1'b0;
        @(negedge Clk); #2 Rst_n = 1'b0;
        #1;
        chk32("abort_valid", {31'd0, Valid}, 32'd0);
        chk32("abort_result", Result, 32'd0);
        @(negedge Clk); #2 Rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge Clk); if (Valid) seen = 1'b1; end
        chk32("abort_no_valid", {31'd0, seen}, 32'd0);
        directed("after_abort", 32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h4040_0000);

        // Back-to-back: second Load on the cycle Valid rises
        @(negedge Clk); Load = 1'b1; A = 32'h4120_0000; B = 32'h3F80_0000; Op = 1'b1;
        @(negedge Clk); Load = 1'b0;
        wait_valid("b2b_first", n);
        chk32("b2b_first", Result, 32'h4110_0000);
        Load = 1'b1; A = 32'h4120_0000; B = 32'h4120_0000; Op = 1'b0;
        low = 0;
        @(negedge Clk); Load = 1'b0;
        while (Valid !== 1'b1 && low < 20) begin low++; @(negedge Clk); end
        chk32("b2b_low_cycles", low, 32'd5);
        chk32("b2b_second", Result, 32'h41A0_0000);

        // Load during the busy window is ignored
        @(negedge Clk); Load = 1'b1; A = 32'h4080_0000; B = 32'h4000_0000; Op = 1'b0;
        @(negedge Clk); Load = 1'b0;
        @(negedge Clk); Load = 1'b1; A = 32'h3F80_0000; B = 32'h3F80_0000; Op = 1'b1;
        @(negedge Clk); Load = 1'b0;
        wait_valid("ignore", n);
        chk32("ignore_busy", Result, 32'h40C0_0000);

        // Randomized traffic, checked cycle-by-cycle against the model
        for (int i = 0; i < 300; i++) begin
            ra  = rnd_fp();
            rop = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = rnd_fp();
                1: rb = ra;
                default: begin
                    rb = $urandom;
                    rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) rb[22:10] = ra[22:10];
                end
            endcase
            @(negedge Clk); Load = 1'b1; A = ra; B = rb; Op = rop;
            if ($urandom_range(0, 7) == 0) @(negedge Clk);
            @(negedge Clk); Load = 1'b0;
            repeat ($urandom_range(1, 8)) @(negedge Clk);
        end

        repeat (10) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
